// File: rtl/uart_wb_bridge.sv
// uart_wb_bridge: host debug master that turns UART command bytes into
// single 32-bit Wishbone reads/writes and returns the reply over the UART.
//   'r' A3 A2 A1 A0           -> reply D3 D2 D1 D0
//   'w' A3 A2 A1 A0 D3..D0    -> reply ok_byte
// Optional feature: define UART_WB_TIMEOUT_EN to abort a bus cycle that sees
// no wb_ack_i within timeout_cycles clocks; the reply is then err_byte only.
module uart_wb_bridge #(
   parameter int unsigned timeout_cycles = 1024,
   parameter logic [7:0]  ok_byte        = 8'h2E,
   parameter logic [7:0]  err_byte       = 8'hEE
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_avail,
   output logic        rx_ack,
   output logic [7:0]  tx_data,
   output logic        tx_wr,
   input  logic        tx_busy,
   output logic [31:0] wb_adr_o,
   output logic [31:0] wb_dat_o,
   input  logic [31:0] wb_dat_i,
   output logic [3:0]  wb_sel_o,
   output logic        wb_we_o,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   input  logic        wb_ack_i,
   output logic        busy
);

   localparam logic [7:0] CMD_RD = 8'h72;
   localparam logic [7:0] CMD_WR = 8'h77;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA,
      ST_BUS,
      ST_REPLY
   } state_t;

   state_t      r_state;
   logic [1:0]  r_cnt;       // byte counter for ADDR/DATA/REPLY
   logic [1:0]  r_last;      // index of the final reply byte (0 or 3)
   logic        r_we;        // latched command type
   logic [31:0] r_reply;     // reply bytes, sent MSB first
   logic        r_rx_ack;
   logic        r_tx_wr;
   logic [7:0]  r_tx_data;
   logic [31:0] r_adr;
   logic [31:0] r_dat;
   logic [3:0]  r_sel;
   logic        r_wb_we;
   logic        r_cyc;
   logic        r_stb;

   logic        w_rx_take;
   logic        w_tx_go;
   logic        w_tmo_hit;

   // A byte is taken only in the byte-collecting states and never in the
   // cycle right after an ack, so a held rx_avail cannot be consumed twice.
   assign w_rx_take = rx_avail && !r_rx_ack &&
                      (r_state == ST_IDLE || r_state == ST_ADDR || r_state == ST_DATA);

   // tx_busy is ignored in the cycle after a strobe; the transmitter may
   // not have raised it yet.
   assign w_tx_go = (r_state == ST_REPLY) && !tx_busy && !r_tx_wr;

`ifdef UART_WB_TIMEOUT_EN
   localparam int unsigned TW = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;

   logic [TW-1:0] r_tmo;

   assign w_tmo_hit = (r_tmo == TW'(timeout_cycles - 1));

   // Ack-timeout counter: counts cycles spent in BUS, cleared elsewhere.
   always_ff @(posedge clk) begin
      if (reset || r_state != ST_BUS) begin
         r_tmo <= '0;
      end else if (!w_tmo_hit) begin
         r_tmo <= r_tmo + 1'b1;
      end
   end
`else
   logic w_unused_tmo;

   assign w_unused_tmo = (timeout_cycles == 32'd0);
   assign w_tmo_hit    = 1'b0;
`endif

   // Command FSM: collects bytes, runs one bus cycle, sends the reply.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_last    <= '0;
         r_we      <= 1'b0;
         r_reply   <= '0;
         r_rx_ack  <= 1'b0;
         r_tx_wr   <= 1'b0;
         r_tx_data <= '0;
         r_adr     <= '0;
         r_dat     <= '0;
         r_sel     <= '0;
         r_wb_we   <= 1'b0;
         r_cyc     <= 1'b0;
         r_stb     <= 1'b0;
      end else begin
         r_rx_ack <= w_rx_take;
         r_tx_wr  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_rx_take && (rx_data == CMD_RD || rx_data == CMD_WR)) begin
                  r_state <= ST_ADDR;
                  r_we    <= (rx_data == CMD_WR);
                  r_cnt   <= '0;
               end
            end
            ST_ADDR: begin
               if (w_rx_take) begin
                  r_adr <= {r_adr[23:0], rx_data};
                  r_cnt <= r_cnt + 2'd1;
                  if (r_cnt == 2'd3) begin
                     if (r_we) begin
                        r_state <= ST_DATA;
                     end else begin
                        r_state <= ST_BUS;
                        r_cyc   <= 1'b1;
                        r_stb   <= 1'b1;
                        r_sel   <= 4'hF;
                        r_wb_we <= 1'b0;
                     end
                  end
               end
            end
            ST_DATA: begin
               if (w_rx_take) begin
                  r_dat <= {r_dat[23:0], rx_data};
                  r_cnt <= r_cnt + 2'd1;
                  if (r_cnt == 2'd3) begin
                     r_state <= ST_BUS;
                     r_cyc   <= 1'b1;
                     r_stb   <= 1'b1;
                     r_sel   <= 4'hF;
                     r_wb_we <= 1'b1;
                  end
               end
            end
            ST_BUS: begin
               // ack has priority over a timeout in the same cycle
               if (wb_ack_i || w_tmo_hit) begin
                  r_state <= ST_REPLY;
                  r_cnt   <= '0;
                  r_cyc   <= 1'b0;
                  r_stb   <= 1'b0;
                  r_sel   <= '0;
                  r_wb_we <= 1'b0;
                  if (wb_ack_i) begin
                     if (r_we) begin
                        r_reply <= {ok_byte, 24'h0};
                        r_last  <= 2'd0;
                     end else begin
                        r_reply <= wb_dat_i;
                        r_last  <= 2'd3;
                     end
                  end else begin
                     r_reply <= {err_byte, 24'h0};
                     r_last  <= 2'd0;
                  end
               end
            end
            ST_REPLY: begin
               if (w_tx_go) begin
                  r_tx_wr   <= 1'b1;
                  r_tx_data <= r_reply[31:24];
                  r_reply   <= {r_reply[23:0], 8'h00};
                  r_cnt     <= r_cnt + 2'd1;
                  if (r_cnt == r_last) begin
                     r_state <= ST_IDLE;
                     r_cnt   <= '0;
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign rx_ack   = r_rx_ack;
   assign tx_wr    = r_tx_wr;
   assign tx_data  = r_tx_data;
   assign wb_adr_o = r_adr;
   assign wb_dat_o = r_dat;
   assign wb_sel_o = r_sel;
   assign wb_we_o  = r_wb_we;
   assign wb_cyc_o = r_cyc;
   assign wb_stb_o = r_stb;
   assign busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_wb_bridge.sv
// Bench for uart_wb_bridge: host byte source, randomized Wishbone slave and
// UART transmitter models, with scoreboard queues for bus cycles and replies.
// Build with UART_WB_TIMEOUT_EN defined to also cover the ack timeout.
`timescale 1ns/1ps
module tb_uart_wb_bridge;

`ifdef UART_WB_TIMEOUT_EN
   localparam int unsigned TMO    = 16;
   localparam bit          TMO_EN = 1'b1;
`else
   localparam int unsigned TMO    = 1024;
   localparam bit          TMO_EN = 1'b0;
`endif
   localparam logic [7:0] OKB  = 8'h2E;
   localparam logic [7:0] ERRB = 8'hEE;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  rx_data;
   logic        rx_avail;
   logic        rx_ack;
   logic [7:0]  tx_data;
   logic        tx_wr;
   logic        tx_busy;
   logic [31:0] wb_adr_o;
   logic [31:0] wb_dat_o;
   logic [31:0] wb_dat_i;
   logic [3:0]  wb_sel_o;
   logic        wb_we_o;
   logic        wb_cyc_o;
   logic        wb_stb_o;
   logic        wb_ack_i;
   logic        busy;

   uart_wb_bridge #(
      .timeout_cycles(TMO),
      .ok_byte       (OKB),
      .err_byte      (ERRB)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .rx_data (rx_data),
      .rx_avail(rx_avail),
      .rx_ack  (rx_ack),
      .tx_data (tx_data),
      .tx_wr   (tx_wr),
      .tx_busy (tx_busy),
      .wb_adr_o(wb_adr_o),
      .wb_dat_o(wb_dat_o),
      .wb_dat_i(wb_dat_i),
      .wb_sel_o(wb_sel_o),
      .wb_we_o (wb_we_o),
      .wb_cyc_o(wb_cyc_o),
      .wb_stb_o(wb_stb_o),
      .wb_ack_i(wb_ack_i),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   // Expected bus cycle: lat = cycles before ack (0 = ack in first cycle), -1 = never
   typedef struct {
      bit          we;
      logic [31:0] adr;
      logic [31:0] dat;
      int          lat;
   } bus_t;

   bus_t        exp_bus[$];
   logic [7:0]  exp_tx[$];
   logic [31:0] ref_mem[logic [31:0]];
   logic [31:0] slv_mem[logic [31:0]];
   int total = 0;
   int bad   = 0;
   int sent  = 0;
   int acks  = 0;
   int tx_stretch = 0;

   function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   // contents of memory never written
   function automatic logic [31:0] dflt(logic [31:0] a);
      return {a[7:0], a[15:8], ~a[23:16], a[31:24]} ^ 32'h5A0F_C3A1;
   endfunction

   // ---------------- Wishbone slave + bus-cycle monitor ----------------
   initial begin : slave
      bus_t e;
      bit   active;
      int   cnt;
      int   exp_len;
      active   = 1'b0;
      cnt      = 0;
      e        = '{1'b0, 32'h0, 32'h0, -1};
      wb_ack_i = 1'b0;
      wb_dat_i = '0;
      forever begin
         @(negedge clk);
         if (reset === 1'b1) begin
            wb_ack_i = 1'b0;
            active   = 1'b0;
            continue;
         end
         if (wb_ack_i) begin
            wb_ack_i = 1'b0;
            wb_dat_i = $urandom;
            check("cyc_stb_drop_after_ack", {wb_cyc_o, wb_stb_o}, 2'b00);
            active = 1'b0;
            continue;
         end
         wb_dat_i = $urandom;
         if (!active && wb_cyc_o === 1'b1) begin
            check("bus_cycle_expected", exp_bus.size() > 0, 1'b1);
            if (exp_bus.size() > 0) begin
               e = exp_bus.pop_front();
               active = 1'b1;
               cnt = 0;
               check("adr", wb_adr_o, e.adr);
               check("we", wb_we_o, e.we);
               check("sel", wb_sel_o, 4'hF);
               check("stb", wb_stb_o, 1'b1);
               check("busy_in_bus", busy, 1'b1);
               if (e.we) check("dat_o", wb_dat_o, e.dat);
            end
         end
         if (active) begin
            if (wb_cyc_o !== 1'b1) begin
               exp_len = (TMO_EN && e.lat < 0) ? int'(TMO) : -1;
               check("cycle_abort_len", cnt, exp_len);
               active = 1'b0;
            end else begin
               cnt++;
               if (e.lat >= 0 && cnt - 1 == e.lat) begin
                  wb_ack_i = 1'b1;
                  if (e.we) slv_mem[e.adr] = e.dat;
                  else      wb_dat_i = slv_mem.exists(e.adr) ? slv_mem[e.adr] : dflt(e.adr);
               end
            end
         end
      end
   end

   // ---------------- UART transmitter model + reply monitor ----------------
   initial begin : monitor
      int left;
      bit busy_prev;
      left      = 0;
      busy_prev = 1'b0;
      tx_busy   = 1'b0;
      forever begin
         @(negedge clk);
         if (rx_ack === 1'b1) acks++;
         if (tx_wr === 1'b1) begin
            check("tx_not_while_busy", busy_prev, 1'b0);
            check("tx_expected", exp_tx.size() > 0, 1'b1);
            if (exp_tx.size() > 0) check("tx_byte", tx_data, exp_tx.pop_front());
            left = tx_stretch;
         end else if (left > 0) begin
            left--;
         end
         tx_busy   = (left > 0);
         busy_prev = tx_busy;
      end
   end

   // ---------------- stimulus ----------------
   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      rx_data  = b;
      rx_avail = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while (rx_ack !== 1'b1 && n < 3000);
      check("rx_accepted", rx_ack, 1'b1);
      sent++;
      rx_avail = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int lat);
      exp_bus.push_back('{1'b1, a, d, lat});
      if (lat >= 0) begin
         ref_mem[a] = d;
         exp_tx.push_back(OKB);
      end else begin
         exp_tx.push_back(ERRB);
      end
      send_byte(8'h77);
      send_word(a);
      send_word(d);
   endtask

   task automatic do_read(input logic [31:0] a, input int lat);
      logic [31:0] v;
      exp_bus.push_back('{1'b0, a, 32'h0, lat});
      if (lat >= 0) begin
         v = ref_mem.exists(a) ? ref_mem[a] : dflt(a);
         for (int i = 3; i >= 0; i--) exp_tx.push_back(v[8*i +: 8]);
      end else begin
         exp_tx.push_back(ERRB);
      end
      send_byte(8'h72);
      send_word(a);
   endtask

   task automatic poke(input logic [31:0] a, input logic [31:0] d);
      ref_mem[a] = d;
      slv_mem[a] = d;
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      repeat (2) @(negedge clk);
      while ((busy !== 1'b0 || exp_tx.size() != 0 || exp_bus.size() != 0) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_tx_pending"}, exp_tx.size(), 0);
      check({tag, "_rx_acks"}, acks, sent);
   endtask

   task automatic reset_mid(input string tag);
      @(negedge clk);
      reset    = 1'b1;
      rx_avail = 1'b0;
      exp_tx.delete();
      exp_bus.delete();
      @(negedge clk);
      check({tag, "_cyc"}, wb_cyc_o, 1'b0);
      check({tag, "_stb"}, wb_stb_o, 1'b0);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_tx_wr"}, tx_wr, 1'b0);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin : main
      int a0;
      int n;
      int r;
      int lat;
      logic [7:0]  jb;
      logic [31:0] addr;
      reset    = 1'b1;
      rx_avail = 1'b0;
      rx_data  = '0;
      repeat (3) @(negedge clk);
      check("rst_rx_ack", rx_ack, 1'b0);
      check("rst_tx_wr", tx_wr, 1'b0);
      check("rst_tx_data", tx_data, 8'h00);
      check("rst_adr", wb_adr_o, 32'h0);
      check("rst_dat", wb_dat_o, 32'h0);
      check("rst_sel", wb_sel_o, 4'h0);
      check("rst_we_cyc_stb", {wb_we_o, wb_cyc_o, wb_stb_o}, 3'b000);
      check("rst_busy", busy, 1'b0);
      reset = 1'b0;
      @(negedge clk);

      // directed write
      tx_stretch = 2;
      do_write(32'h1000_0004, 32'hDEAD_BEEF, 2);
      wait_idle("write");

      // directed read, slave returns 12345678 after 3 cycles
      poke(32'h1000_0004, 32'h1234_5678);
      a0 = acks;
      do_read(32'h1000_0004, 3);
      wait_idle("read");
      check("read_rx_ack_pulses", acks - a0, 5);

      // junk bytes then back-to-back read acked in first cycle, slow transmitter
      tx_stretch = 100;
      send_byte(8'h67);
      send_byte(8'h00);
      do_read(32'h0, 0);
      do_write(32'h0000_0008, 32'hCAFE_F00D, 1);
      do_read(32'h0000_0008, 0);
      wait_idle("junk_b2b");

      // reset in DATA after two data bytes
      tx_stretch = 1;
      send_byte(8'h77);
      send_word(32'hAAAA_0000);
      send_byte(8'h11);
      send_byte(8'h22);
      reset_mid("rst_data");

      // reset in BUS with cyc held (no ack)
      exp_bus.push_back('{1'b1, 32'hBBBB_0000, 32'h5555_6666, -1});
      send_byte(8'h77);
      send_word(32'hBBBB_0000);
      send_word(32'h5555_6666);
      n = 0;
      while (wb_cyc_o !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("cyc_before_reset", wb_cyc_o, 1'b1);
      repeat (3) @(negedge clk);
      reset_mid("rst_bus");

      do_write(32'hBBBB_0000, 32'h0102_0304, 2);
      do_read(32'hBBBB_0000, 1);
      wait_idle("after_reset");

`ifdef UART_WB_TIMEOUT_EN
      do_read(32'h0000_0020, -1);
      wait_idle("tmo_read");
      do_read(32'h0000_0020, int'(TMO) - 1);
      wait_idle("tmo_ack_wins");
      do_write(32'h0000_0024, 32'h7777_8888, -1);
      do_read(32'h0000_0024, 0);
      wait_idle("tmo_write");
`endif

      // randomized traffic
      for (int it = 0; it < 40; it++) begin
         tx_stretch = ($urandom_range(0, 9) == 0) ? 100 : int'($urandom_range(0, 3));
         if ($urandom_range(0, 4) == 0) begin
            jb = 8'($urandom_range(0, 255));
            if (jb == 8'h72 || jb == 8'h77) jb = 8'h00;
            send_byte(jb);
         end
         r = $urandom_range(0, 3);
         addr = (r == 0) ? 32'h0 : (r == 1) ? 32'h4 : (r == 2) ? 32'h1000_0004 : $urandom;
         lat = $urandom_range(0, 4);
         if (TMO_EN) begin
            r = $urandom_range(0, 9);
            if (r == 0) lat = -1;
            else if (r == 1) lat = int'(TMO) - 1;
         end
         if ($urandom_range(0, 1) == 0) do_write(addr, $urandom, lat);
         else                           do_read(addr, lat);
         if ($urandom_range(0, 1) == 0) wait_idle("rand");
      end
      wait_idle("final");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_wb_bridge.md
Name: uart_wb_bridge

Overview:
- Debug bus master between the UART byte interface (rx_data/rx_avail/rx_ack, tx_data/tx_wr/tx_busy) and the system Wishbone bus.
- Consumes command bytes from the UART receiver, issues single 32-bit Wishbone reads and writes, and returns reply bytes through the UART transmitter.
- Lets the host peek and poke memory and peripherals, including DDR, without CPU involvement.

Parameters:
- timeout_cycles, 1024: Wishbone ack timeout in clk cycles. Used only when the optional feature is compiled in.
- ok_byte, 8'h2E: reply byte for a completed write.
- err_byte, 8'hEE: reply byte for an aborted transaction.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- rx_data  input  8  received byte from UART
- rx_avail  input  1  received byte valid; held until acked
- rx_ack  output  1  one-cycle pulse; consumes rx_data
- tx_data  output  8  byte to transmit
- tx_wr  output  1  one-cycle transmit strobe
- tx_busy  input  1  transmitter busy
- wb_adr_o  output  32  Wishbone address
- wb_dat_o  output  32  Wishbone write data
- wb_dat_i  input  32  Wishbone read data
- wb_sel_o  output  4  byte selects; always 4'hF during a cycle
- wb_we_o  output  1  write enable
- wb_cyc_o  output  1  bus cycle
- wb_stb_o  output  1  strobe
- wb_ack_i  input  1  acknowledge
- busy  output  1  high in every state except IDLE

Behaviour:
- Single clock domain: clk. Reset is synchronous and active-high on port reset.
- Reset values: all outputs 0, state IDLE, counters and shift registers 0. Reset mid-operation drops cyc/stb in the same edge. A partially received command is discarded and no reply is sent.
- RX handshake:
  - When rx_avail=1 and no ack was issued in the previous cycle, latch rx_data and pulse rx_ack for one cycle.
  - rx_avail is ignored in the cycle after an rx_ack pulse, so one byte is never consumed twice.
- TX handshake:
  - In TX states, when tx_busy=0 and no tx_wr was issued in the previous cycle, drive tx_data and pulse tx_wr for one cycle.
  - tx_busy is not sampled in the cycle after tx_wr.
- Command bytes:
  - 'r' (8'h72): 4 address bytes, MSB first. Reply is 4 data bytes, MSB first.
  - 'w' (8'h77): 4 address bytes, then 4 data bytes, both MSB first. Reply is ok_byte.
  - Any other byte in IDLE is consumed and ignored: no reply, state stays IDLE.
- States:
  - IDLE -> ADDR on 'r' or 'w'. Latch we = (byte=='w'). Clear byte counter.
  - ADDR: shift each byte into wb_adr_o. The 4th byte goes to DATA if we=1, otherwise to BUS.
  - DATA: shift 4 bytes into wb_dat_o. 4th byte -> BUS.
  - BUS: cyc=stb=1, we per latch, sel=4'hF.
    - On wb_ack_i: deassert cyc/stb on the next edge.
    - For a read, capture wb_dat_i into the reply register in the same edge.
    - Then go to REPLY.
    - An ack arriving in the first BUS cycle is legal. Minimum bus latency is 1 cycle.
  - REPLY: send 1 byte (write/error) or 4 bytes (read). After the last tx_wr, return to IDLE.
- Bytes arriving during BUS or REPLY stay pending in the UART (rx_ack held 0). They are processed after the return to IDLE.
- Addresses are passed through unaligned. The slave decides how to handle them.
- Counters are 2 bits and wrap at 3 -> 0 exactly at the state transition.

Optional Feature:
- Macro UART_WB_TIMEOUT_EN.
- Defined:
  - A counter runs in BUS from 0. If it reaches timeout_cycles-1 without wb_ack_i, cyc/stb drop on the next edge and REPLY sends the single byte err_byte.
  - For reads, no data bytes are sent.
  - If ack and timeout coincide, ack wins.
- Undefined: BUS waits indefinitely for wb_ack_i. err_byte is never sent.

Test Plan:
- Write: send 77 10 00 00 04 DE AD BE EF -> one cycle with adr=32'h10000004, dat_o=32'hDEADBEEF, we=1, sel=F; tx byte 2E; busy returns to 0.
- Read: send 72 10 00 00 04 with slave returning 32'h12345678 after 3 cycles -> we=0; tx bytes 12 34 56 78 in order; exactly 5 rx_ack pulses.
- Junk and back-to-back: send 67 00 then 72 00 00 00 00 with ack in the first cycle -> 67 and 00 are consumed with no bus cycle and no reply; the read completes; tx busy stretched 100 cycles between bytes -> no lost or duplicated bytes.
- Reset mid-operation: assert reset during DATA after 2 data bytes, and again during BUS with cyc=1 -> next cycle cyc=stb=0, state IDLE, no tx; a following full write completes normally.
- Timeout (UART_WB_TIMEOUT_EN, timeout_cycles=16): read with no ack -> cyc drops after 16 cycles; tx byte EE only. Ack in cycle 16 instead -> normal 4-byte reply.
